ezlogic_stream_checker: RTL and testbench

- Sink end of the EzLogic byte stream.
- Consumes the data_out/valid_out stream produced by EzLogic_top and compares each byte against a compile-time expected vector.
- Reports pass/fail, mismatch count, first failing index, timeout and overrun.
- Replaces ad-hoc capture-and-compare logic, so the same check runs in simulation and on FPGA (status to LEDs/UART).

---
 rtl/ezlogic_stream_checker.sv | 159 +++++++++++++++
 tb/tb_ezlogic_stream_checker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ezlogic_stream_checker.sv
// Sink-side checker for the EzLogic byte stream: compares each valid byte against a
// compile-time expected vector and reports pass/fail, mismatch statistics, timeout and overrun.
module ezlogic_stream_checker #(
    parameter int unsigned    N        = 42,
    parameter logic [8*N-1:0] EXPECTED = 336'h30789d5692f2fe23bb2c5d9e16406653b6cb217c952998ce17b7143788d949952680b4bce4c30a96c753,
    parameter int unsigned    TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] mismatch_count,
    output logic [6:0] first_err_idx,
    output logic [6:0] byte_count,
    output logic       timeout,
    output logic       overrun
);

    localparam int unsigned IDX_W = 7;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] IDX_NONE = IDX_W'(127);

    if (N < 1 || N > 127) begin : g_bad_n
        $error("ezlogic_stream_checker: N must be in 1..127");
    end
    if (TIMEOUT < N) begin : g_bad_timeout
        $error("ezlogic_stream_checker: TIMEOUT must be >= N");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state, w_state;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic               r_pass, w_pass;
    logic [IDX_W-1:0]   r_mm, w_mm;
    logic [IDX_W-1:0]   r_first, w_first;
    logic [IDX_W-1:0]   r_bc, w_bc;
    logic               r_to, w_to;
    logic               r_ov, w_ov;
    logic [CNT_W-1:0]   r_cyc, w_cyc;
    logic               w_arm;
    logic [7:0]         w_exp_byte;

    // Byte 0 sits in the most significant byte of EXPECTED.
    assign w_exp_byte = EXPECTED[(8*N-1) - 8*32'(r_bc) -: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_mm    <= '0;
            r_first <= IDX_NONE;
            r_bc    <= '0;
            r_to    <= 1'b0;
            r_ov    <= 1'b0;
            r_cyc   <= '0;
        end else begin
            r_state <= w_state;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pass  <= w_pass;
            r_mm    <= w_mm;
            r_first <= w_first;
            r_bc    <= w_bc;
            r_to    <= w_to;
            r_ov    <= w_ov;
            r_cyc   <= w_cyc;
        end
    end

    always_comb begin
        w_state = r_state;
        w_busy  = r_busy;
        w_done  = r_done;
        w_pass  = r_pass;
        w_mm    = r_mm;
        w_first = r_first;
        w_bc    = r_bc;
        w_to    = r_to;
        w_ov    = r_ov;
        w_cyc   = r_cyc;
        w_arm   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_arm = start;
            end
            S_RUN: begin
                w_cyc = r_cyc + CNT_W'(1);
                if (valid_in) begin
                    if (data_in != w_exp_byte) begin
                        if (r_mm != IDX_NONE) begin
                            w_mm = r_mm + IDX_W'(1);
                        end
                        if (r_first == IDX_NONE) begin
                            w_first = r_bc;
                        end
                    end
                    w_bc = r_bc + IDX_W'(1);
                end
                // Completing the stream takes priority over a coincident timeout.
                if (valid_in && (w_bc == IDX_W'(N))) begin
                    w_state = S_DONE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_pass  = (w_mm == '0);
                end else if (w_cyc == CNT_W'(TIMEOUT)) begin
                    w_state = S_DONE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_pass  = 1'b0;
                    w_to    = 1'b1;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_arm = 1'b1;
                end else if (valid_in) begin
                    w_ov   = 1'b1;
                    w_pass = 1'b0;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Arming clears every result exactly as reset does.
        if (w_arm) begin
            w_state = S_RUN;
            w_busy  = 1'b1;
            w_done  = 1'b0;
            w_pass  = 1'b0;
            w_mm    = '0;
            w_first = IDX_NONE;
            w_bc    = '0;
            w_to    = 1'b0;
            w_ov    = 1'b0;
            w_cyc   = '0;
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign mismatch_count = r_mm;
    assign first_err_idx  = r_first;
    assign byte_count     = r_bc;
    assign timeout        = r_to;
    assign overrun        = r_ov;

endmodule

// File: tb/tb_ezlogic_stream_checker.sv
// Bench for ezlogic_stream_checker: directed scenarios plus random traffic, every cycle
// compared against a rule-level reference model of the checker.
module tb_ezlogic_stream_checker;

    localparam int unsigned N  = 42;
    localparam int unsigned TO = 128;
    localparam logic [8*N-1:0] EXP = 336'h30789d5692f2fe23bb2c5d9e16406653b6cb217c952998ce17b7143788d949952680b4bce4c30a96c753;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       busy, done, pass, timeout, overrun;
    logic [6:0] mismatch_count, first_err_idx, byte_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0] gold [N];

    // Reference model state: phase 0 = idle, 1 = run, 2 = done.
    int m_phase, m_cnt, m_mm, m_first, m_cyc, m_to, m_ov, m_pass;

    always #5 clk = ~clk;

    ezlogic_stream_checker #(.N(N), .EXPECTED(EXP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .valid_in(valid_in),
        .busy(busy), .done(done), .pass(pass), .mismatch_count(mismatch_count),
        .first_err_idx(first_err_idx), .byte_count(byte_count),
        .timeout(timeout), .overrun(overrun)
    );

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0; m_mm = 0; m_first = 127; m_cyc = 0; m_to = 0; m_ov = 0; m_pass = 0;
    endtask

    task automatic model_step(input logic r, input logic s, input logic v, input logic [7:0] d);
        if (r) begin
            m_phase = 0;
            model_clear();
        end else if (m_phase == 0) begin
            if (s) begin
                m_phase = 1;
                model_clear();
            end
        end else if (m_phase == 1) begin
            m_cyc++;
            if (v) begin
                if (d != gold[m_cnt]) begin
                    m_mm = (m_mm < 127) ? m_mm + 1 : 127;
                    if (m_first == 127) m_first = m_cnt;
                end
                m_cnt++;
            end
            if (m_cnt == N) begin
                m_phase = 2;
                m_pass  = (m_mm == 0) ? 1 : 0;
            end else if (m_cyc >= TO) begin
                m_phase = 2;
                m_to    = 1;
                m_pass  = 0;
            end
        end else begin
            if (s) begin
                m_phase = 1;
                model_clear();
            end else if (v) begin
                m_ov   = 1;
                m_pass = 0;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("busy", busy, (m_phase == 1) ? 1 : 0);
        check_eq("done", done, (m_phase == 2) ? 1 : 0);
        check_eq("pass", pass, m_pass);
        check_eq("mismatch_count", mismatch_count, m_mm);
        check_eq("first_err_idx", first_err_idx, m_first);
        check_eq("byte_count", byte_count, m_cnt);
        check_eq("timeout", timeout, m_to);
        check_eq("overrun", overrun, m_ov);
    endtask

    // One clock: drive on the falling edge, advance the model on the rising edge, sample 1ns later.
    task automatic step(input logic r, input logic s, input logic v, input logic [7:0] d);
        @(negedge clk);
        rst = r; start = s; valid_in = v; data_in = d;
        @(posedge clk);
        model_step(r, s, v, d);
        #1;
        compare_all();
    endtask

    task automatic send_golden();
        for (int k = 0; k < N; k++) step(1'b0, 1'b0, 1'b1, gold[k]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8*N-1:0] vec;
        int cyc;
        vec = EXP;
        for (int k = 0; k < N; k++) gold[k] = vec[8*N-1-8*k -: 8];
        m_phase = 0;
        model_clear();

        // Reset state
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'h30);
        check_eq("rst_first_err", first_err_idx, 127);
        check_eq("rst_busy", busy, 0);

        // Golden stream, back to back
        step(1'b0, 1'b1, 1'b0, 8'h00);
        send_golden();
        check_eq("gold_done", done, 1);
        check_eq("gold_pass", pass, 1);
        check_eq("gold_mm", mismatch_count, 0);
        check_eq("gold_first", first_err_idx, 127);
        check_eq("gold_bc", byte_count, 42);

        // Two corrupt bytes, 1-on / 2-off gapping
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < N; k++) begin
            logic [7:0] d;
            d = gold[k];
            if (k == 5)  d = 8'hff;
            if (k == 40) d = 8'h00;
            step(1'b0, 1'b0, 1'b1, d);
            if (k < N - 1) begin
                step(1'b0, 1'b0, 1'b0, 8'h00);
                step(1'b0, 1'b0, 1'b0, 8'h00);
            end
        end
        check_eq("bad_done", done, 1);
        check_eq("bad_pass", pass, 0);
        check_eq("bad_mm", mismatch_count, 2);
        check_eq("bad_first", first_err_idx, 5);
        check_eq("bad_bc", byte_count, 42);

        // Timeout after a partial stream
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        cyc = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b1, gold[k]);
            cyc++;
        end
        while (!done && cyc < TO + 10) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            cyc++;
        end
        check_eq("to_latency", cyc, TO);
        check_eq("to_flag", timeout, 1);
        check_eq("to_pass", pass, 0);
        check_eq("to_bc", byte_count, 10);

        // Overrun after a complete run, then re-arm with a coincident byte
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        send_golden();
        step(1'b0, 1'b0, 1'b1, 8'h55);
        check_eq("ov_flag", overrun, 1);
        check_eq("ov_pass", pass, 0);
        check_eq("ov_bc", byte_count, 42);
        step(1'b0, 1'b1, 1'b1, 8'h30);
        check_eq("rearm_busy", busy, 1);
        check_eq("rearm_ov", overrun, 0);
        check_eq("rearm_bc", byte_count, 0);
        check_eq("rearm_done", done, 0);

        // Byte on the start cycle is ignored; start mid-run does not restart
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h30);
        for (int k = 0; k < N; k++) step(1'b0, (k == 20) ? 1'b1 : 1'b0, 1'b1, gold[k]);
        check_eq("sc_pass", pass, 1);
        check_eq("sc_bc", byte_count, 42);

        // Reset mid-run, then bytes without start are ignored
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 17; k++) step(1'b0, 1'b0, 1'b1, gold[k]);
        check_eq("mid_bc_pre", byte_count, 17);
        step(1'b1, 1'b0, 1'b1, gold[17]);
        check_eq("mid_busy", busy, 0);
        check_eq("mid_done", done, 0);
        check_eq("mid_bc", byte_count, 0);
        for (int k = 17; k < 27; k++) step(1'b0, 1'b0, 1'b1, gold[k]);
        check_eq("mid_idle_bc", byte_count, 0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic r, s, v;
            logic [7:0] d;
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 2) != 0);
            if (m_cnt < N && $urandom_range(0, 9) != 0) d = gold[m_cnt];
            else d = 8'($urandom);
            step(r, s, v, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
